// File: rtl/video_pattern_source_if.sv
// Avalon-ST video beat bundle: 24-bit RGB pixel with packet framing.
// The master drives data and framing, the slave returns ready.
interface video_pattern_source_if;
    logic [23:0] src_data;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        src_valid;
    logic        src_ready;

    modport master (
        output src_data,
        output src_startofpacket,
        output src_endofpacket,
        output src_valid,
        input  src_ready
    );

    modport slave (
        input  src_data,
        input  src_startofpacket,
        input  src_endofpacket,
        input  src_valid,
        output src_ready
    );
endinterface

// File: rtl/video_pattern_source.sv
// Test-pattern frame generator: bars, gradient, solid or checker
// frames streamed as Avalon-ST packets with an idle gap between frames.
module video_pattern_source #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int FRAME_GAP = 16
) (
    input  logic                  pixel_clk_clk,
    input  logic                  pixel_reset_reset,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [23:0]           solid_color,
    video_pattern_source_if.master src,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] B_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic [15:0] G_LAST = 16'((FRAME_GAP == 0) ? 0 : FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t      state;
    logic [11:0] x, y, bcol;
    logic [2:0]  bar;
    logic [1:0]  pat_q;
    logic [23:0] color_q;
    logic [15:0] gap_cnt;
    logic [15:0] frame_cnt_q;

    logic [11:0] nx, ny, nbcol;
    logic [2:0]  nbar;
    logic        x_last;

    assign frame_count = frame_cnt_q;

    function automatic logic [23:0] bar_rgb(input logic [2:0] b);
        logic [23:0] v;
        v = 24'h000000;
        case (b)
            3'd0:    v = 24'hFFFFFF;
            3'd1:    v = 24'hFFFF00;
            3'd2:    v = 24'h00FFFF;
            3'd3:    v = 24'h00FF00;
            3'd4:    v = 24'hFF00FF;
            3'd5:    v = 24'hFF0000;
            3'd6:    v = 24'h0000FF;
            default: v = 24'h000000;
        endcase
        return v;
    endfunction

    function automatic logic [23:0] pixel(
        input logic [1:0]  p,
        input logic [23:0] c,
        input logic [7:0]  px,
        input logic [7:0]  py,
        input logic [2:0]  b,
        input logic [7:0]  fc
    );
        logic [23:0] v;
        v = 24'h000000;
        case (p)
            2'd0:    v = bar_rgb(b);
            2'd1:    v = {px, py, fc};
            2'd2:    v = c;
            default: v = (px[3] ^ py[3]) ? 24'hFFFFFF : 24'h000000;
        endcase
        return v;
    endfunction

    // Next coordinate and bar position; the bar counter replaces x / (H/8).
    always_comb begin
        x_last = (x == X_LAST);
        nx     = x_last ? 12'd0 : x + 12'd1;
        ny     = y;
        if (x_last)
            ny = (y == Y_LAST) ? 12'd0 : y + 12'd1;
        nbcol  = (x_last || bcol == B_LAST) ? 12'd0 : bcol + 12'd1;
        nbar   = bar;
        if (x_last)
            nbar = 3'd0;
        else if (bcol == B_LAST)
            nbar = bar + 3'd1;
    end

    always_ff @(posedge pixel_clk_clk) begin
        if (pixel_reset_reset) begin
            state                 <= IDLE;
            x                     <= '0;
            y                     <= '0;
            bcol                  <= '0;
            bar                   <= '0;
            pat_q                 <= '0;
            color_q               <= '0;
            gap_cnt               <= '0;
            frame_cnt_q           <= '0;
            frame_done            <= 1'b0;
            src.src_valid         <= 1'b0;
            src.src_startofpacket <= 1'b0;
            src.src_endofpacket   <= 1'b0;
            src.src_data          <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state                 <= STREAM;
                        pat_q                 <= pattern_sel;
                        color_q               <= solid_color;
                        x                     <= '0;
                        y                     <= '0;
                        bcol                  <= '0;
                        bar                   <= '0;
                        src.src_valid         <= 1'b1;
                        src.src_startofpacket <= 1'b1;
                        src.src_endofpacket   <= 1'b0;
                        src.src_data          <= pixel(pattern_sel, solid_color,
                                                       8'd0, 8'd0, 3'd0,
                                                       frame_cnt_q[7:0]);
                    end
                end
                STREAM: begin
                    if (src.src_ready) begin
                        if (src.src_endofpacket) begin
                            state                 <= (FRAME_GAP == 0) ? IDLE : GAP;
                            frame_done            <= 1'b1;
                            frame_cnt_q           <= frame_cnt_q + 16'd1;
                            x                     <= '0;
                            y                     <= '0;
                            bcol                  <= '0;
                            bar                   <= '0;
                            gap_cnt               <= '0;
                            src.src_valid         <= 1'b0;
                            src.src_startofpacket <= 1'b0;
                            src.src_endofpacket   <= 1'b0;
                            src.src_data          <= '0;
                        end else begin
                            x                     <= nx;
                            y                     <= ny;
                            bcol                  <= nbcol;
                            bar                   <= nbar;
                            src.src_startofpacket <= (nx == 12'd0) && (ny == 12'd0);
                            src.src_endofpacket   <= (nx == X_LAST) && (ny == Y_LAST);
                            src.src_data          <= pixel(pat_q, color_q,
                                                           nx[7:0], ny[7:0], nbar,
                                                           frame_cnt_q[7:0]);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                    if (gap_cnt == G_LAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/video_pattern_source.md
VIDEO_PATTERN_SOURCE -- requirements
Module: video_pattern_source

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 320: pixels per line; a multiple of 8, range 8..4095.
REQ-002 The block SHALL have parameter V_ACTIVE, default 240: lines per frame; range 1..4095.
REQ-003 The block SHALL have parameter FRAME_GAP, default 16: idle cycles between frames; range 0..65535.
REQ-004 The block SHALL have port pixel_clk_clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 The block SHALL have port pixel_reset_reset  in  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port enable  in  1  run frames while high.
REQ-007 The block SHALL have port pattern_sel  in  2  pattern select.
REQ-008 The block SHALL have port solid_color  in  24  RGB888 for solid mode.
REQ-009 The block SHALL have port src_data  out  24  pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-010 The block SHALL have port src_startofpacket  out  1  first pixel of frame.
REQ-011 The block SHALL have port src_endofpacket  out  1  last pixel of frame.
REQ-012 The block SHALL have port src_valid  out  1  beat valid.
REQ-013 The block SHALL have port src_ready  in  1  sink accepts; ready latency 0.
REQ-014 The block SHALL have port frame_done  out  1  one-cycle pulse after each EOP transfer.
REQ-015 The block SHALL have port frame_count  out  16  completed frames, wraps at 0xFFFF->0.

Function
REQ-016 The block SHALL implement an Avalon-ST source: a beat transfers on a cycle with src_valid=1 and src_ready=1.
REQ-017 While src_valid=1 and src_ready=0, src_data, src_startofpacket and src_endofpacket SHALL hold unchanged.
REQ-018 The FSM SHALL have states IDLE, STREAM and GAP.
REQ-019 IDLE->STREAM SHALL occur when enable=1; on that edge pattern_sel and solid_color are latched for the whole frame.
REQ-020 In STREAM, src_valid SHALL be 1 every cycle; the first beat of the frame is presented on the cycle after the IDLE->STREAM transition.
REQ-021 Column x SHALL count 0..H_ACTIVE-1 and row y 0..V_ACTIVE-1; both advance only on transfer; x wraps to 0 with y+1.
REQ-022 src_startofpacket SHALL be 1 only when x=0 and y=0; src_endofpacket SHALL be 1 only when x=H_ACTIVE-1 and y=V_ACTIVE-1.
REQ-023 For H_ACTIVE=8 and V_ACTIVE=1, SOP and EOP SHALL fall on different beats.
REQ-024 On the EOP transfer: frame_done pulses 1 on the next cycle, frame_count increments by 1, x and y clear, and the FSM goes to GAP (or to IDLE if FRAME_GAP=0).
REQ-025 GAP SHALL hold src_valid=0 for exactly FRAME_GAP cycles, then go to IDLE.
REQ-026 From IDLE, the next frame SHALL start only if enable=1.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame: the frame completes with EOP, then the block idles.
REQ-028 Pattern 0, colour bars: bar index b=0..7 in steps of H_ACTIVE/8 columns, generated by a column-within-bar counter; no divider.
REQ-029 Bar colours SHALL be FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-030 Pattern 1, gradient: R=x[7:0], G=y[7:0], B=frame_count[7:0].
REQ-031 Pattern 2, solid: the latched solid_color.
REQ-032 Pattern 3, checker: FFFFFF when x[3]^y[3]=1, otherwise 000000.
REQ-033 src_data SHALL be registered; the pixel for coordinate (x,y) is presented together with that coordinate's SOP/EOP flags.
REQ-034 Outside STREAM, src_data, src_startofpacket and src_endofpacket SHALL be 0.

Reset
REQ-035 On pixel_reset_reset=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-036 Reset SHALL clear x, y, frame_count, latched pattern/colour, src_valid, src_startofpacket, src_endofpacket, src_data and frame_done to 0.
REQ-037 Reset SHALL take priority over all other inputs, including mid-frame and mid-stall; the partial frame is abandoned with no EOP.
REQ-038 After reset deasserts, the first frame SHALL begin with SOP at x=0, y=0.

Verification (H_ACTIVE=8, V_ACTIVE=2, FRAME_GAP=3)
REQ-039 enable=1, pattern_sel=0, src_ready=1 -> 16 beats: data FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, repeated; SOP on beat 0; EOP on beat 15; frame_done pulses; frame_count=1; 3 cycles with valid=0.
REQ-040 src_ready toggled 1,0,0,1 pseudo-randomly, pattern 1 -> data, SOP and EOP stable across stalls; beat k carries R=k%8, G=k/8, B=0; exactly 16 transfers.
REQ-041 enable dropped after beat 5 -> all 16 beats still delivered with EOP, then valid stays 0.
REQ-042 pattern_sel=2, solid_color=123456, solid_color changed to ABCDEF mid-frame -> all beats 123456; the next frame uses ABCDEF.
REQ-043 Reset asserted during beat 9 while stalled -> next cycle valid=0, frame_count=0; after release, the first beat has SOP=1 at x=0, y=0.
REQ-044 Force frame_count=0xFFFF before an EOP -> frame_count wraps to 0x0000 and frame_done still pulses.
